// File: rtl/alu_operand_collector.sv
// rtl/alu_operand_collector.sv - assembles head/A/B flit packets into ALU operands
module alu_operand_collector #(
  parameter int WIDTH  = 32,
  parameter int FLIT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_valid,
  input  logic              flit_head,
  output logic              flit_ready,
  output logic [WIDTH-1:0]  src_a,
  output logic [WIDTH-1:0]  src_b,
  output logic [1:0]        ALU_Control,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              frame_err
);

  localparam int NFLITS = WIDTH / FLIT_W;
  localparam int IDX_W  = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFLITS - 1);

  // Operands must split into whole flits and the head must carry a 2-bit opcode
  generate
    if (((WIDTH % FLIT_W) != 0) || (FLIT_W < 2)) begin : g_bad_params
      $error("alu_operand_collector: WIDTH must be a multiple of FLIT_W and FLIT_W >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             xfer;
  logic             err_d;
  logic             load_op;
  logic             wr_a;
  logic             wr_b;

  // Handshake outputs are pure decodes of the state register
  assign flit_ready = (state_q != ISSUE);
  assign op_valid   = (state_q == ISSUE);
  assign xfer       = flit_valid & flit_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, flit index and datapath strobes; a head mid-packet restarts assembly
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    load_op = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (flit_head) begin
            load_op = 1'b1;
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (xfer) begin
          if (flit_head) begin
            err_d   = 1'b1;
            load_op = 1'b1;
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            wr_a = (state_q == LOAD_A);
            wr_b = (state_q == LOAD_B);
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = (state_q == LOAD_A) ? LOAD_B : ISSUE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (op_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/opcode registers, flit index and registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      src_a       <= '0;
      src_b       <= '0;
      ALU_Control <= 2'b00;
      frame_err   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      frame_err <= err_d;
      if (load_op) begin
        ALU_Control <= flit_in[1:0];
      end
      if (wr_a) begin
        src_a[idx_q*FLIT_W +: FLIT_W] <= flit_in;
      end
      if (wr_b) begin
        src_b[idx_q*FLIT_W +: FLIT_W] <= flit_in;
      end
    end
  end

endmodule
